// File: rtl/toy_itcm_arb.sv
// Two-requester ITCM fetch arbiter with credit-gated issue and per-requester response FIFOs.
// Define TOY_ITCM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

module toy_itcm_arb_rsp_fifo #(
  parameter int WIDTH = 134,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             vld,
  output logic [WIDTH-1:0] dout,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    remaining;
  logic [WIDTH-1:0] head_q;
  logic             do_pop;

  assign vld       = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && vld;
  assign remaining = count - CW'(do_pop);
  assign dout      = head_q;

  // NOTE: storage is not reset; only pointers, count and the head register are,
  // so reset cost stays independent of DEPTH and entries are never read before written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Head register keeps the output registered: it always holds the oldest entry,
  // taking the incoming word directly when no older entry survives this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
      if (remaining == '0) begin
        if (push) head_q <= din;
      end else if (do_pop) begin
        head_q <= mem[rd_ptr + AW'(1)];
      end
    end
  end
endmodule

module toy_itcm_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 6,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0: demand fetch
  input  logic                  r0_req_vld,
  output logic                  r0_req_rdy,
  input  logic [ADDR_WIDTH-1:0] r0_req_addr,
  input  logic [ID_WIDTH-1:0]   r0_req_entry_id,
  output logic                  r0_ack_vld,
  input  logic                  r0_ack_rdy,
  output logic [DATA_WIDTH-1:0] r0_ack_data,
  output logic [ID_WIDTH-1:0]   r0_ack_entry_id,
  // requester 1: prefetch / debug
  input  logic                  r1_req_vld,
  output logic                  r1_req_rdy,
  input  logic [ADDR_WIDTH-1:0] r1_req_addr,
  input  logic [ID_WIDTH-1:0]   r1_req_entry_id,
  output logic                  r1_ack_vld,
  input  logic                  r1_ack_rdy,
  output logic [DATA_WIDTH-1:0] r1_ack_data,
  output logic [ID_WIDTH-1:0]   r1_ack_entry_id,
  // ITCM port
  output logic                  mem_req_vld,
  input  logic                  mem_req_rdy,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [ID_WIDTH-1:0]   mem_req_entry_id,
  input  logic                  mem_ack_vld,
  input  logic [DATA_WIDTH-1:0] mem_ack_data,
  input  logic [ID_WIDTH-1:0]   mem_ack_entry_id,
  output logic                  mem_ack_rdy,
  output logic                  err_orphan_ack
);
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int OQ_DEPTH = 2 * DEPTH;
  localparam int OAW      = $clog2(OQ_DEPTH);
  localparam int OCW      = OAW + 1;
  localparam int RW       = ID_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  function automatic logic [CW-1:0] cred_next(input logic [CW-1:0] cnt,
                                               input logic inc, input logic dec);
    logic [CW-1:0] res;
    res = cnt;
    case ({inc, dec})
      2'b10:   res = cnt + CW'(1);
      2'b01:   res = cnt - CW'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

  logic [CW-1:0] cnt0, cnt1;
  logic          elig0, elig1, win1, gnt0, gnt1;
  logic          mem_hs, req_hs0, req_hs1, ack_hs0, ack_hs1;

`ifdef TOY_ITCM_ARB_RR_EN
  logic rr_ptr;  // requester preferred when both are eligible
`endif

  // NOTE: every signal assigned in this block gets a value on every path,
  // so no latch is inferred.
  always_comb begin
    elig0 = !rst && r0_req_vld && (cnt0 < CRED_MAX);
    elig1 = !rst && r1_req_vld && (cnt1 < CRED_MAX);
`ifdef TOY_ITCM_ARB_RR_EN
    win1  = elig1 && (!elig0 || rr_ptr);
`else
    win1  = elig1 && !elig0;
`endif
    gnt0  = elig0 && !win1;
    gnt1  = win1;
  end

  assign mem_req_vld      = elig0 || elig1;
  assign mem_req_addr     = win1 ? r1_req_addr     : r0_req_addr;
  assign mem_req_entry_id = win1 ? r1_req_entry_id : r0_req_entry_id;
  assign r0_req_rdy       = gnt0 && mem_req_rdy;
  assign r1_req_rdy       = gnt1 && mem_req_rdy;
  assign mem_hs           = mem_req_vld && mem_req_rdy;
  assign req_hs0          = r0_req_vld && r0_req_rdy;
  assign req_hs1          = r1_req_vld && r1_req_rdy;
  assign ack_hs0          = r0_ack_vld && r0_ack_rdy;
  assign ack_hs1          = r1_ack_vld && r1_ack_rdy;
  assign mem_ack_rdy      = 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= cred_next(cnt0, req_hs0, ack_hs0);
      cnt1 <= cred_next(cnt1, req_hs1, ack_hs1);
    end
  end

`ifdef TOY_ITCM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= 1'b0;
    else if (mem_hs) rr_ptr <= !win1;
  end
`endif

  // Order queue: source id of each issued request, popped by the in-order ITCM acks.
  logic [OQ_DEPTH-1:0] oq_src;
  logic [OAW-1:0]      oq_wr, oq_rd;
  logic [OCW-1:0]      oq_cnt;
  logic                oq_empty, oq_pop, oq_head;

  assign oq_empty = (oq_cnt == '0);
  assign oq_pop   = mem_ack_vld && !oq_empty;
  assign oq_head  = oq_src[oq_rd];

  always_ff @(posedge clk) begin
    if (mem_hs) oq_src[oq_wr] <= win1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oq_wr  <= '0;
      oq_rd  <= '0;
      oq_cnt <= '0;
    end else begin
      if (mem_hs) oq_wr <= oq_wr + OAW'(1);
      if (oq_pop) oq_rd <= oq_rd + OAW'(1);
      oq_cnt <= oq_cnt + OCW'(mem_hs) - OCW'(oq_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          err_orphan_ack <= 1'b0;
    else if (mem_ack_vld && oq_empty) err_orphan_ack <= 1'b1;
  end

  logic          rsp_push0, rsp_push1, rsp_full0, rsp_full1;
  logic [RW-1:0] rsp_din, rsp_dout0, rsp_dout1;

  assign rsp_din   = {mem_ack_entry_id, mem_ack_data};
  assign rsp_push0 = oq_pop && !oq_head;
  assign rsp_push1 = oq_pop && oq_head;

  toy_itcm_arb_rsp_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_rsp0 (
    .clk  (clk),
    .rst  (rst),
    .push (rsp_push0),
    .din  (rsp_din),
    .pop  (r0_ack_rdy),
    .vld  (r0_ack_vld),
    .dout (rsp_dout0),
    .full (rsp_full0)
  );

  toy_itcm_arb_rsp_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_rsp1 (
    .clk  (clk),
    .rst  (rst),
    .push (rsp_push1),
    .din  (rsp_din),
    .pop  (r1_ack_rdy),
    .vld  (r1_ack_vld),
    .dout (rsp_dout1),
    .full (rsp_full1)
  );

  assign {r0_ack_entry_id, r0_ack_data} = rsp_dout0;
  assign {r1_ack_entry_id, r1_ack_data} = rsp_dout1;

  // Credits make these unreachable; firing means the credit accounting is broken.
  a_rsp0_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_push0 && rsp_full0 && !ack_hs0));
  a_rsp1_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_push1 && rsp_full1 && !ack_hs1));
  a_oq_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(mem_hs && !oq_pop && (oq_cnt == OCW'(OQ_DEPTH))));
endmodule

// File: tb/tb_toy_itcm_arb.sv
// Directed self-checking bench for toy_itcm_arb with a 1-cycle ITCM model and per-requester scoreboards.
// Arbitration expectations follow TOY_ITCM_ARB_RR_EN when it is defined for the build.

module tb_toy_itcm_arb;
  logic         clk = 1'b0;
  logic         rst;
  logic         r0_req_vld, r0_req_rdy, r0_ack_vld, r0_ack_rdy;
  logic [31:0]  r0_req_addr;
  logic [5:0]   r0_req_entry_id, r0_ack_entry_id;
  logic [127:0] r0_ack_data;
  logic         r1_req_vld, r1_req_rdy, r1_ack_vld, r1_ack_rdy;
  logic [31:0]  r1_req_addr;
  logic [5:0]   r1_req_entry_id, r1_ack_entry_id;
  logic [127:0] r1_ack_data;
  logic         mem_req_vld, mem_req_rdy, mem_ack_vld, mem_ack_rdy;
  logic [31:0]  mem_req_addr;
  logic [5:0]   mem_req_entry_id, mem_ack_entry_id;
  logic [127:0] mem_ack_data;
  logic         err_orphan_ack;

  int n_vec  = 0;
  int n_miss = 0;
  int n0 = 0;
  int n1 = 0;
  logic [31:0] q0_addr[$], q1_addr[$];
  logic [5:0]  q0_id[$],   q1_id[$];

  always #5 clk = ~clk;

  toy_itcm_arb dut (
    .clk              (clk),
    .rst              (rst),
    .r0_req_vld       (r0_req_vld),
    .r0_req_rdy       (r0_req_rdy),
    .r0_req_addr      (r0_req_addr),
    .r0_req_entry_id  (r0_req_entry_id),
    .r0_ack_vld       (r0_ack_vld),
    .r0_ack_rdy       (r0_ack_rdy),
    .r0_ack_data      (r0_ack_data),
    .r0_ack_entry_id  (r0_ack_entry_id),
    .r1_req_vld       (r1_req_vld),
    .r1_req_rdy       (r1_req_rdy),
    .r1_req_addr      (r1_req_addr),
    .r1_req_entry_id  (r1_req_entry_id),
    .r1_ack_vld       (r1_ack_vld),
    .r1_ack_rdy       (r1_ack_rdy),
    .r1_ack_data      (r1_ack_data),
    .r1_ack_entry_id  (r1_ack_entry_id),
    .mem_req_vld      (mem_req_vld),
    .mem_req_rdy      (mem_req_rdy),
    .mem_req_addr     (mem_req_addr),
    .mem_req_entry_id (mem_req_entry_id),
    .mem_ack_vld      (mem_ack_vld),
    .mem_ack_data     (mem_ack_data),
    .mem_ack_entry_id (mem_ack_entry_id),
    .mem_ack_rdy      (mem_ack_rdy),
    .err_orphan_ack   (err_orphan_ack)
  );

  function automatic logic [127:0] itcm_data(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5a5a_5a5a, a + 32'h0000_1234};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_r0();
    r0_req_vld = 1'b1; r0_req_addr = 32'h1000 + 32'(n0 * 4); r0_req_entry_id = 6'(n0);
  endtask

  task automatic set_r1();
    r1_req_vld = 1'b1; r1_req_addr = 32'h2000 + 32'(n1 * 4); r1_req_entry_id = 6'(n1 ^ 32);
  endtask

  // Scoreboard the current cycle, advance one clock, then play the ITCM ack.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    logic [5:0]  id;
    #1;
    if (r0_ack_vld && r0_ack_rdy) begin
      if (q0_id.size() == 0) check("r0_unexpected_ack", {127'd0, r0_ack_vld}, 128'd0);
      else begin
        check("r0_ack_id", r0_ack_entry_id, q0_id.pop_front());
        check("r0_ack_data", r0_ack_data, itcm_data(q0_addr.pop_front()));
      end
    end
    if (r1_ack_vld && r1_ack_rdy) begin
      if (q1_id.size() == 0) check("r1_unexpected_ack", {127'd0, r1_ack_vld}, 128'd0);
      else begin
        check("r1_ack_id", r1_ack_entry_id, q1_id.pop_front());
        check("r1_ack_data", r1_ack_data, itcm_data(q1_addr.pop_front()));
      end
    end
    if (r0_req_vld && r0_req_rdy) begin
      q0_addr.push_back(r0_req_addr); q0_id.push_back(r0_req_entry_id); n0++;
    end
    if (r1_req_vld && r1_req_rdy) begin
      q1_addr.push_back(r1_req_addr); q1_id.push_back(r1_req_entry_id); n1++;
    end
    hs = mem_req_vld && mem_req_rdy;
    a  = mem_req_addr;
    id = mem_req_entry_id;
    @(posedge clk);
    #1;
    mem_ack_vld      = hs;
    mem_ack_data     = itcm_data(a);
    mem_ack_entry_id = id;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0_addr.delete(); q0_id.delete(); q1_addr.delete(); q1_id.delete();
    tick(); tick();
    rst = 1'b0;
    r0_req_vld = 1'b0; r1_req_vld = 1'b0;
  endtask

  task automatic drain(input string tag);
    r0_req_vld = 1'b0; r1_req_vld = 1'b0; r0_ack_rdy = 1'b1; r1_ack_rdy = 1'b1;
    repeat (8) tick();
    #1;
    check({tag, "_q0_empty"}, q0_id.size(), 0);
    check({tag, "_q1_empty"}, q1_id.size(), 0);
    check({tag, "_r0_ack_idle"}, r0_ack_vld, 1'b0);
    check({tag, "_r1_ack_idle"}, r1_ack_vld, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_w;
    rst = 1'b1;
    r0_req_vld = 1'b1; r0_req_addr = 32'h0; r0_req_entry_id = '0; r0_ack_rdy = 1'b1;
    r1_req_vld = 1'b1; r1_req_addr = 32'h0; r1_req_entry_id = '0; r1_ack_rdy = 1'b1;
    mem_req_rdy = 1'b1; mem_ack_vld = 1'b0; mem_ack_data = '0; mem_ack_entry_id = '0;
    tick(); tick();

    // Reset values, with both requesters asserting valid through reset
    #1;
    check("rst_mem_req_vld", mem_req_vld, 1'b0);
    check("rst_r0_req_rdy", r0_req_rdy, 1'b0);
    check("rst_r1_req_rdy", r1_req_rdy, 1'b0);
    check("rst_r0_ack_vld", r0_ack_vld, 1'b0);
    check("rst_r1_ack_vld", r1_ack_vld, 1'b0);
    check("rst_r0_ack_data", r0_ack_data, 128'd0);
    check("rst_r0_ack_id", r0_ack_entry_id, 6'd0);
    check("rst_err", err_orphan_ack, 1'b0);
    check("mem_ack_rdy", mem_ack_rdy, 1'b1);
    do_reset();

    // Single r0 request, first stalled by mem_req_rdy
    r0_req_vld = 1'b1; r0_req_addr = 32'h100; r0_req_entry_id = 6'd5; mem_req_rdy = 1'b0;
    #1;
    check("t1_stall_mem_vld", mem_req_vld, 1'b1);
    check("t1_stall_r0_rdy", r0_req_rdy, 1'b0);
    tick();
    mem_req_rdy = 1'b1;
    #1;
    check("t1_mem_vld", mem_req_vld, 1'b1);
    check("t1_mem_addr", mem_req_addr, 32'h100);
    check("t1_mem_id", mem_req_entry_id, 6'd5);
    check("t1_r0_rdy", r0_req_rdy, 1'b1);
    check("t1_r1_rdy", r1_req_rdy, 1'b0);
    tick();
    r0_req_vld = 1'b0;
    #1;
    check("t1_no_early_ack", r0_ack_vld, 1'b0);
    tick();
    #1;
    check("t1_r0_ack_vld", r0_ack_vld, 1'b1);
    check("t1_r0_ack_id", r0_ack_entry_id, 6'd5);
    check("t1_r0_ack_data", r0_ack_data, itcm_data(32'h100));
    check("t1_r1_ack_vld", r1_ack_vld, 1'b0);
    tick();
    #1;
    check("t1_r0_ack_done", r0_ack_vld, 1'b0);
    check("t1_q0_empty", q0_id.size(), 0);

    // Both requesters valid every cycle
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_r0(); set_r1();
`ifdef TOY_ITCM_ARB_RR_EN
      exp_w = k % 2;
`else
      exp_w = 0;
`endif
      #1;
      check("arb_r0_rdy", r0_req_rdy, exp_w == 0);
      check("arb_r1_rdy", r1_req_rdy, exp_w == 1);
      check("arb_mem_id", mem_req_entry_id, (exp_w == 1) ? 6'(n1 ^ 32) : 6'(n0));
      tick();
    end
    r0_req_vld = 1'b0; set_r1();
    #1;
    check("arb_r1_after_drop", r1_req_rdy, 1'b1);
    check("arb_r0_after_drop", r0_req_rdy, 1'b0);
    tick();
    drain("arb");

    // Credit exhaustion with r0 responses held
    do_reset();
    r0_ack_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_r0();
      #1;
      check("cred_r0_rdy", r0_req_rdy, k < 4);
      tick();
    end
    set_r0(); r0_ack_rdy = 1'b1;
    #1;
    check("cred_no_comb_path", r0_req_rdy, 1'b0);
    check("cred_r0_ack_vld", r0_ack_vld, 1'b1);
    tick();
    set_r0(); r0_ack_rdy = 1'b0;
    #1;
    check("cred_freed_rdy", r0_req_rdy, 1'b1);
    tick();
    set_r0();
    #1;
    check("cred_refull_rdy", r0_req_rdy, 1'b0);
    tick();
    drain("cred");

    // Orphan ack
    do_reset();
    mem_ack_vld = 1'b1; mem_ack_data = 128'hdead; mem_ack_entry_id = 6'd7;
    #1;
    check("orphan_err_not_yet", err_orphan_ack, 1'b0);
    tick();
    #1;
    check("orphan_err_set", err_orphan_ack, 1'b1);
    check("orphan_r0_ack_vld", r0_ack_vld, 1'b0);
    check("orphan_r1_ack_vld", r1_ack_vld, 1'b0);
    tick(); tick();
    #1;
    check("orphan_err_sticky", err_orphan_ack, 1'b1);
    check("orphan_r0_ack_vld_late", r0_ack_vld, 1'b0);
    do_reset();
    #1;
    check("orphan_err_cleared", err_orphan_ack, 1'b0);

    // Reset with three requests in flight
    r0_ack_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_r0();
      #1;
      check("rmid_issue_rdy", r0_req_rdy, 1'b1);
      tick();
    end
    rst = 1'b1;
    q0_addr.delete(); q0_id.delete();
    tick();
    #1;
    check("rmid_r0_ack_vld", r0_ack_vld, 1'b0);
    check("rmid_r0_ack_data", r0_ack_data, 128'd0);
    check("rmid_r0_ack_id", r0_ack_entry_id, 6'd0);
    check("rmid_mem_req_vld", mem_req_vld, 1'b0);
    check("rmid_r0_req_rdy", r0_req_rdy, 1'b0);
    check("rmid_err", err_orphan_ack, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_r0();
      #1;
      check("rmid_cred_rdy", r0_req_rdy, k < 4);
      tick();
    end
    check("rmid_err_after", err_orphan_ack, 1'b0);
    drain("rmid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
